// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter feeding the outbound UART message FIFO through a one-entry
// holding buffer, with optional fixed priority for requester 0.
module uart_msg_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int MSG_WIDTH  = 32,
  parameter int HIPRI_REQ0 = 0
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [MSG_WIDTH-1:0]         out_msg,
  output logic                         out_wr_en,
  input  logic                         out_full,
  output logic                         busy
);

  localparam int          GW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic [MSG_WIDTH-1:0]   out_msg_q, out_msg_d;

  logic [MSG_WIDTH-1:0]   msg_arr [NUM_REQ];
  logic [GW-1:0]          win;
  logic [GW-1:0]          idx;
  logic                   found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign msg_arr[g] = req_msg[g*MSG_WIDTH +: MSG_WIDTH];
  end

  // Scan starts one past the last grant so the previous winner goes to the back.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (HIPRI_REQ0 != 0 && req_valid[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      idx = GW'((32'(last_grant_q) + k) % NREQ_U);
      if (!found && req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_ack_d    = '0;
    out_msg_d    = out_msg_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          out_msg_d      = msg_arr[win];
          req_ack_d[win] = 1'b1;
          last_grant_d   = win;
          state_d        = WRITE;
        end
      end
      WRITE: begin
        if (!out_full) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      req_ack_q    <= '0;
      out_msg_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_ack_q    <= req_ack_d;
      out_msg_q    <= out_msg_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign out_msg   = out_msg_q;
  assign busy      = (state_q == WRITE);
  // Combinational so the strobe tracks the FIFO's same-cycle full flag.
  assign out_wr_en = (state_q == WRITE) && !out_full;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model, for round-robin and priority builds.
module tb_uart_msg_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           n_reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_msg = '0;
  logic           out_full = 1'b0;

  logic [N-1:0]   ack_a, ack_b;
  logic [W-1:0]   msg_a, msg_b;
  logic           wr_a, wr_b, busy_a, busy_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_msg_arbiter #(.NUM_REQ(N), .MSG_WIDTH(W), .HIPRI_REQ0(0)) dut_rr (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_msg(req_msg),
    .req_ack(ack_a), .out_msg(msg_a), .out_wr_en(wr_a), .out_full(out_full), .busy(busy_a)
  );

  uart_msg_arbiter #(.NUM_REQ(N), .MSG_WIDTH(W), .HIPRI_REQ0(1)) dut_hp (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_msg(req_msg),
    .req_ack(ack_b), .out_msg(msg_b), .out_wr_en(wr_b), .out_full(out_full), .busy(busy_b)
  );

  // Reference model: index 0 = round-robin build, index 1 = requester-0 priority build.
  bit           m_busy [2];
  logic [N-1:0] m_ack  [2];
  logic [W-1:0] m_msg  [2];
  int           m_last [2];

  function automatic int pick(int hp, int last, logic [N-1:0] v);
    if (hp != 0 && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge n_reset) begin
    for (int c = 0; c < 2; c++) begin
      if (!n_reset) begin
        m_busy[c] = 1'b0;
        m_ack[c]  = '0;
        m_msg[c]  = '0;
        m_last[c] = N - 1;
      end else if (m_busy[c]) begin
        m_ack[c] = '0;
        if (!out_full) m_busy[c] = 1'b0;
      end else begin
        int w;
        w = pick(c, m_last[c], req_valid);
        m_ack[c] = '0;
        if (w >= 0) begin
          m_busy[c]   = 1'b1;
          m_ack[c][w] = 1'b1;
          m_msg[c]    = req_msg[w*W +: W];
          m_last[c]   = w;
        end
      end
    end
  end

  task automatic reset_dut();
    n_reset   = 1'b0;
    req_valid = '0;
    req_msg   = '0;
    out_full  = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    req_valid = '1;
    @(negedge clk);
    total++; if (ack_a !== 3'b000) $display("FAIL reset_ack_rr: got %b want 000", ack_a); else passed++;
    total++; if (msg_a !== 32'h0) $display("FAIL reset_msg_rr: got %h want 0", msg_a); else passed++;
    total++; if (wr_a !== 1'b0) $display("FAIL reset_wr_rr: got %b want 0", wr_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy_rr: got %b want 0", busy_a); else passed++;
    total++; if ({ack_b, msg_b, wr_b, busy_b} !== '0)
      $display("FAIL reset_hp: got ack=%b msg=%h wr=%b busy=%b want all 0", ack_b, msg_b, wr_b, busy_b);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_single();
    int writes = 0;
    reset_dut();
    req_msg[0 +: W] = 32'hA5A5_0001;
    req_valid = 3'b001;
    @(negedge clk);
    total++; if (ack_a !== 3'b001) $display("FAIL single_ack: got %b want 001", ack_a); else passed++;
    total++; if (busy_a !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_a); else passed++;
    total++; if (wr_a !== 1'b1) $display("FAIL single_wr: got %b want 1", wr_a); else passed++;
    total++; if (msg_a !== 32'hA5A5_0001) $display("FAIL single_msg: got %h want a5a50001", msg_a); else passed++;
    req_valid = '0;
    @(negedge clk);
    total++; if ({ack_a, wr_a, busy_a} !== 5'b0)
      $display("FAIL single_idle: got ack=%b wr=%b busy=%b want 000/0/0", ack_a, wr_a, busy_a);
    else passed++;
    total++; if (msg_a !== 32'hA5A5_0001) $display("FAIL single_msg_hold: got %h want a5a50001", msg_a); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (wr_a) writes++;
    end
    total++; if (writes !== 0) $display("FAIL single_extra_writes: got %0d want 0", writes); else passed++;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] got [$];
    logic [N-1:0] acks [$];
    reset_dut();
    req_msg   = {32'h3, 32'h2, 32'h1};
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++; if (wr_a !== 1'((i % 2) == 0))
        $display("FAIL rr_cadence: cycle %0d got wr=%b want %b", i, wr_a, (i % 2) == 0);
      else passed++;
      if (wr_a === 1'b1) begin
        got.push_back(msg_a);
        acks.push_back(ack_a);
      end
    end
    req_valid = '0;
    total++; if (got.size() !== 6) $display("FAIL rr_count: got %0d want 6", got.size()); else passed++;
    for (int k = 0; k < got.size() && k < 6; k++) begin
      total++; if (got[k] !== W'(k % 3 + 1))
        $display("FAIL rr_msg: write %0d got %h want %h", k, got[k], k % 3 + 1);
      else passed++;
      total++; if (acks[k] !== N'(1 << (k % 3)))
        $display("FAIL rr_ack: write %0d got %b want %b", k, acks[k], N'(1 << (k % 3)));
      else passed++;
    end
  endtask

  task automatic test_full_backpressure();
    reset_dut();
    req_msg[0 +: W] = 32'hDEAD_0000;
    req_msg[W +: W] = 32'hBEEF_0001;
    req_valid = 3'b011;
    out_full  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if (ack_a !== 3'b001) $display("FAIL full_first_ack: got %b want 001", ack_a); else passed++;
        req_valid[0] = 1'b0;
      end
      total++; if ({wr_a, busy_a, msg_a, ack_a[1]} !== {1'b0, 1'b1, 32'hDEAD_0000, 1'b0})
        $display("FAIL full_hold: cycle %0d got wr=%b busy=%b msg=%h ack1=%b want 0/1/dead0000/0",
                 i, wr_a, busy_a, msg_a, ack_a[1]);
      else passed++;
    end
    out_full = 1'b0;
    #1;
    total++; if ({wr_a, msg_a} !== {1'b1, 32'hDEAD_0000})
      $display("FAIL full_release_wr: got wr=%b msg=%h want 1/dead0000", wr_a, msg_a);
    else passed++;
    @(negedge clk);
    total++; if ({wr_a, busy_a} !== 2'b00) $display("FAIL full_idle: got wr=%b busy=%b want 0/0", wr_a, busy_a); else passed++;
    @(negedge clk);
    total++; if ({ack_a, msg_a, wr_a} !== {3'b010, 32'hBEEF_0001, 1'b1})
      $display("FAIL full_next_grant: got ack=%b msg=%h wr=%b want 010/beef0001/1", ack_a, msg_a, wr_a);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_hipri();
    reset_dut();
    req_msg   = {32'hC2, 32'h0, 32'hC0};
    req_valid = 3'b101;
    @(negedge clk);
    total++; if ({ack_b, msg_b} !== {3'b001, 32'hC0})
      $display("FAIL hp_first: got ack=%b msg=%h want 001/c0", ack_b, msg_b);
    else passed++;
    req_msg[0 +: W] = 32'hC1;
    @(negedge clk);
    @(negedge clk);
    total++; if ({ack_b, msg_b} !== {3'b001, 32'hC1})
      $display("FAIL hp_again: got ack=%b msg=%h want 001/c1", ack_b, msg_b);
    else passed++;
    total++; if ({ack_a, msg_a} !== {3'b100, 32'hC2})
      $display("FAIL hp_rr_compare: got ack=%b msg=%h want 100/c2", ack_a, msg_a);
    else passed++;
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if ({ack_b, msg_b} !== {3'b100, 32'hC2})
      $display("FAIL hp_then_req2: got ack=%b msg=%h want 100/c2", ack_b, msg_b);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_pulse_during_write();
    int writes = 0;
    reset_dut();
    req_msg   = {32'h0, 32'h5151_0001, 32'h5050_0000};
    req_valid = 3'b001;
    @(negedge clk);
    total++; if ({ack_a, wr_a} !== {3'b001, 1'b1}) $display("FAIL pulse_setup: got ack=%b wr=%b want 001/1", ack_a, wr_a); else passed++;
    req_valid = 3'b010;
    @(negedge clk);
    req_valid = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_a === 1'b1) writes++;
      total++; if (ack_a[1] !== 1'b0) $display("FAIL pulse_ack: cycle %0d got ack1=%b want 0", i, ack_a[1]); else passed++;
    end
    total++; if (writes !== 0) $display("FAIL pulse_writes: got %0d want 0", writes); else passed++;
  endtask

  task automatic test_reset_mid_write();
    int writes = 0;
    reset_dut();
    req_msg[0 +: W] = 32'h1234_5678;
    req_valid = 3'b001;
    out_full  = 1'b1;
    @(negedge clk);
    total++; if (busy_a !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy_a); else passed++;
    req_valid = '0;
    #2;
    n_reset = 1'b0;
    #1;
    total++; if ({ack_a, msg_a, wr_a, busy_a} !== '0)
      $display("FAIL midrst_async: got ack=%b msg=%h wr=%b busy=%b want all 0", ack_a, msg_a, wr_a, busy_a);
    else passed++;
    out_full = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_a === 1'b1) writes++;
    end
    total++; if (writes !== 0) $display("FAIL midrst_writes: got %0d want 0", writes); else passed++;
    n_reset   = 1'b1;
    req_msg   = {32'h3, 32'h2, 32'h1};
    req_valid = 3'b111;
    @(negedge clk);
    total++; if ({ack_a, msg_a} !== {3'b001, 32'h1})
      $display("FAIL midrst_priority: got ack=%b msg=%h want 001/1", ack_a, msg_a);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N+W+1:0] exp_v;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      exp_v = {m_ack[0], m_msg[0], m_busy[0] & ~out_full, m_busy[0]};
      total++; if ({ack_a, msg_a, wr_a, busy_a} !== exp_v)
        $display("FAIL rand_rr: cycle %0d got ack=%b msg=%h wr=%b busy=%b want ack=%b msg=%h wr=%b busy=%b",
                 i, ack_a, msg_a, wr_a, busy_a, exp_v[N+W+1:W+2], exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
      exp_v = {m_ack[1], m_msg[1], m_busy[1] & ~out_full, m_busy[1]};
      total++; if ({ack_b, msg_b, wr_b, busy_b} !== exp_v)
        $display("FAIL rand_hp: cycle %0d got ack=%b msg=%h wr=%b busy=%b want ack=%b msg=%h wr=%b busy=%b",
                 i, ack_b, msg_b, wr_b, busy_b, exp_v[N+W+1:W+2], exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
      req_valid = N'($urandom_range(0, 7));
      for (int r = 0; r < N; r++) req_msg[r*W +: W] = $urandom;
      out_full = ($urandom_range(0, 3) == 0);
    end
    req_valid = '0;
    out_full  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_backpressure();
    test_hipri();
    test_pulse_during_write();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
